// File: rtl/gpio_seq_if.sv
// Wishbone data-bus bundle for the gpio sequencer.
// Master drives the request side, slave returns rdt/ack.
interface gpio_seq_if;
  logic [31:0] wb_dbus_adr;
  logic [31:0] wb_dbus_dat;
  logic [3:0]  wb_dbus_sel;
  logic        wb_dbus_we;
  logic        wb_dbus_cyc;
  logic [31:0] rdt;
  logic        ack;

  modport master (
    output wb_dbus_adr, wb_dbus_dat, wb_dbus_sel,
    output wb_dbus_we, wb_dbus_cyc,
    input  rdt, ack
  );

  modport slave (
    input  wb_dbus_adr, wb_dbus_dat, wb_dbus_sel,
    input  wb_dbus_we, wb_dbus_cyc,
    output rdt, ack
  );
endinterface

// File: rtl/gpio_seq.sv
// Wishbone gpio sequencer: FIFO of (value, hold) entries played onto gpio.
// Optional GPIO_SEQ_IRQ_EN adds a low-water/underrun irq output.
module gpio_seq #(
  parameter int ADDR       = 0,
  parameter int AWIDTH     = 8,
  parameter int DEPTH_LOG2 = 3,
  parameter int PRESCALE   = 1000,
  parameter int LOW_WATER  = 2
) (
  input  logic       wb_clk,
  input  logic       wb_rst,
  gpio_seq_if.slave  bus,
`ifdef GPIO_SEQ_IRQ_EN
  output logic       irq,
`endif
  output logic [7:0] gpio
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PMAX = PW'(PRESCALE - 1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] HOLD = 1'b1;

  logic [0:0]            state;
  logic                  ack_q;
  logic                  en;
  logic                  underrun;
  logic                  overflow;
  logic [PW-1:0]         presc;
  logic [15:0]           hold_cnt;
  logic [23:0]           mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wptr;
  logic [DEPTH_LOG2-1:0] rptr;
  logic [DEPTH_LOG2:0]   count;

  logic        sel;
  logic        wr;
  logic [1:0]  rsel;
  logic        push_req;
  logic        push_ok;
  logic        flush;
  logic        pop;
  logic        empty;
  logic        full;
  logic        busy;
  logic        tick;
  logic [7:0]  head_val;
  logic [15:0] head_hold;
  logic [15:0] ld_hold;
  logic [31:0] status;
  logic [31:0] rdt_c;
  logic        irq_q;

  wire unused_bits = ^{bus.wb_dbus_sel, bus.wb_dbus_adr[1:0],
                       bus.wb_dbus_adr[31-AWIDTH:4],
                       bus.wb_dbus_dat[15:8]};

  assign sel = bus.wb_dbus_cyc && !ack_q &&
               (bus.wb_dbus_adr[31 -: AWIDTH] == AWIDTH'(ADDR));
  assign wr   = sel && bus.wb_dbus_we;
  assign rsel = bus.wb_dbus_adr[3:2];

  assign empty = (count == '0);
  assign full  = count[DEPTH_LOG2];
  assign busy  = (state == HOLD);
  assign tick  = (presc == PMAX);

  assign push_req = wr && (rsel == 2'd1);
  assign push_ok  = push_req && !full;
  assign flush    = wr && (rsel == 2'd0) && bus.wb_dbus_dat[1];

  assign head_val  = mem[rptr][23:16];
  assign head_hold = mem[rptr][15:0];
  assign ld_hold   = (head_hold == 16'd0) ? 16'd1 : head_hold;

  // Pop when starting from idle, or when the current entry ends with more queued.
  assign pop = en && !empty &&
               (!busy || (tick && hold_cnt == 16'd1));

  always_ff @(posedge wb_clk) begin
    if (push_ok)
      mem[wptr] <= {bus.wb_dbus_dat[7:0], bus.wb_dbus_dat[31:16]};
  end

  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      ack_q    <= 1'b0;
      en       <= 1'b0;
      state    <= IDLE;
      gpio     <= 8'h00;
      presc    <= '0;
      hold_cnt <= 16'd0;
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      underrun <= 1'b0;
      overflow <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      ack_q <= sel;
      if (wr && rsel == 2'd0)
        en <= bus.wb_dbus_dat[0];
      if (wr && rsel == 2'd2) begin
        if (bus.wb_dbus_dat[16]) underrun <= 1'b0;
        if (bus.wb_dbus_dat[17]) overflow <= 1'b0;
      end
      if (push_req && full)
        overflow <= 1'b1;
      if (wr && rsel == 2'd3 && !busy)
        gpio <= bus.wb_dbus_dat[7:0];

      if (flush) begin
        wptr  <= '0;
        rptr  <= '0;
        count <= '0;
      end else begin
        if (push_ok) wptr <= wptr + 1'b1;
        if (pop)     rptr <= rptr + 1'b1;
        count <= count + (DEPTH_LOG2+1)'(push_ok)
                       - (DEPTH_LOG2+1)'(pop);
      end

      unique case (state)
        IDLE: begin
          presc <= '0;
          if (en && !empty) begin
            state    <= HOLD;
            gpio     <= head_val;
            hold_cnt <= ld_hold;
          end
        end
        HOLD: begin
          if (!en) begin
            state <= IDLE;
            presc <= '0;
          end else if (tick) begin
            presc <= '0;
            if (hold_cnt != 16'd1) begin
              hold_cnt <= hold_cnt - 16'd1;
            end else if (!empty) begin
              gpio     <= head_val;
              hold_cnt <= ld_hold;
            end else begin
              state    <= IDLE;
              hold_cnt <= 16'd0;
              underrun <= 1'b1;
            end
          end else begin
            presc <= presc + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase

      irq_q <= en && ((32'(count) <= 32'(LOW_WATER)) || underrun);
    end
  end

  always_comb begin
    status = 32'h0;
    status[DEPTH_LOG2:0] = count;
    status[8]  = empty;
    status[9]  = full;
    status[10] = busy;
`ifdef GPIO_SEQ_IRQ_EN
    status[11] = irq_q;
`endif
    status[16] = underrun;
    status[17] = overflow;
  end

  always_comb begin
    rdt_c = 32'h0;
    unique case (rsel)
      2'd0: rdt_c = {31'h0, en};
      2'd1: rdt_c = 32'h0;
      2'd2: rdt_c = status;
      2'd3: rdt_c = {24'h0, gpio};
      default: rdt_c = 32'h0;
    endcase
  end

  assign bus.rdt = rdt_c;
  assign bus.ack = ack_q;

`ifdef GPIO_SEQ_IRQ_EN
  assign irq = irq_q;
`else
  wire unused_irq = irq_q;
`endif

endmodule

// File: tb/tb_gpio_seq.sv
// Directed bench for gpio_seq (PRESCALE=4, DEPTH_LOG2=3).
// Define GPIO_SEQ_IRQ_EN for both RTL and bench to cover the irq path.
module tb_gpio_seq;

  localparam logic [31:0] A_CTRL = 32'h0;
  localparam logic [31:0] A_PUSH = 32'h4;
  localparam logic [31:0] A_STAT = 32'h8;
  localparam logic [31:0] A_DIR  = 32'hC;
`ifdef GPIO_SEQ_IRQ_EN
  localparam logic [31:0] IRQ_B = 32'h800;
`else
  localparam logic [31:0] IRQ_B = 32'h0;
`endif

  logic       wb_clk = 1'b0;
  logic       wb_rst;
  logic [7:0] gpio;
`ifdef GPIO_SEQ_IRQ_EN
  logic       irq;
`endif

  int n_cmp = 0;
  int n_err = 0;
  logic ack_after;
  logic [31:0] rd;

  gpio_seq_if bus ();

  gpio_seq #(
    .ADDR(0), .AWIDTH(8), .DEPTH_LOG2(3),
    .PRESCALE(4), .LOW_WATER(2)
  ) dut (
    .wb_clk (wb_clk),
    .wb_rst (wb_rst),
    .bus    (bus.slave),
`ifdef GPIO_SEQ_IRQ_EN
    .irq    (irq),
`endif
    .gpio   (gpio)
  );

  always #5 wb_clk = ~wb_clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge wb_clk);
    #1;
  endtask

  task automatic xfer(input logic we,
                      input logic [31:0] adr,
                      input logic [31:0] wd,
                      output logic [31:0] rdat);
    bus.wb_dbus_adr = adr;
    bus.wb_dbus_dat = wd;
    bus.wb_dbus_we  = we;
    bus.wb_dbus_cyc = 1'b1;
    rdat = 32'h0;
    for (int n = 0; n < 8 && !bus.ack; n++) step();
    if (!bus.ack) chk("ack_timeout", 32'(bus.ack), 32'h1);
    else rdat = bus.rdt;
    bus.wb_dbus_cyc = 1'b0;
    bus.wb_dbus_we  = 1'b0;
    step();
    ack_after = bus.ack;
  endtask

  task automatic wr(input logic [31:0] adr, input logic [31:0] d);
    logic [31:0] dummy;
    xfer(1'b1, adr, d, dummy);
  endtask

  task automatic rdr(input logic [31:0] adr, output logic [31:0] d);
    xfer(1'b0, adr, 32'h0, d);
  endtask

  task automatic wait_idle();
    logic [31:0] s;
    s = 32'h400;
    for (int k = 0; k < 100 && s[10]; k++) rdr(A_STAT, s);
    chk("wait_idle", 32'(s[10]), 32'h0);
  endtask

  initial begin
    bus.wb_dbus_adr = 32'h0;
    bus.wb_dbus_dat = 32'h0;
    bus.wb_dbus_sel = 4'hF;
    bus.wb_dbus_we  = 1'b0;
    bus.wb_dbus_cyc = 1'b0;
    wb_rst = 1'b1;
    repeat (3) step();
    chk("rst_ack", 32'(bus.ack), 32'h0);
    chk("rst_gpio", 32'(gpio), 32'h0);
    wb_rst = 1'b0;
    step();

    // reset state reads
    rdr(A_STAT, rd);
    chk("rst_status", rd, 32'h100);
    chk("ack_1cyc_a", 32'(ack_after), 32'h0);
    rdr(A_DIR, rd);
    chk("rst_direct", rd, 32'h0);
    chk("ack_1cyc_b", 32'(ack_after), 32'h0);
    rdr(A_PUSH, rd);
    chk("push_reads0", rd, 32'h0);

    // basic sequence: A5 x3 ticks, 3C x1 tick
    wr(A_PUSH, 32'h0003_00A5);
    wr(A_PUSH, 32'h0000_003C);
    wr(A_CTRL, 32'h1);
    chk("seq_a5_0", 32'(gpio), 32'hA5);
    for (int i = 1; i < 12; i++) begin
      step();
      chk($sformatf("seq_a5_%0d", i), 32'(gpio), 32'hA5);
    end
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("seq_3c_%0d", i), 32'(gpio), 32'h3C);
    end
    rdr(A_STAT, rd);
    chk("seq_underrun", rd, 32'h0001_0100 | IRQ_B);
    chk("seq_gpio_held", 32'(gpio), 32'h3C);

    // overflow and flush with en=0
    wr(A_CTRL, 32'h0);
    wr(A_STAT, 32'h0003_0000);
    for (int i = 0; i < 9; i++)
      wr(A_PUSH, 32'h0001_0000 | 32'(i));
    rdr(A_STAT, rd);
    chk("ovf_status", rd, 32'h0002_0208);
    wr(A_STAT, 32'h0002_0000);
    rdr(A_STAT, rd);
    chk("ovf_w1c", rd, 32'h0000_0208);
    wr(A_CTRL, 32'h2);
    rdr(A_STAT, rd);
    chk("flush_status", rd, 32'h100);
    rdr(A_CTRL, rd);
    chk("flush_ctrl", rd, 32'h0);

    // direct writes ignored while busy
    wr(A_PUSH, 32'h0064_0011);
    wr(A_CTRL, 32'h1);
    chk("dir_run", 32'(gpio), 32'h11);
    wr(A_DIR, 32'h55);
    chk("dir_busy", 32'(gpio), 32'h11);
    wr(A_CTRL, 32'h0);
    wait_idle();
    rdr(A_STAT, rd);
    chk("stop_status", rd, 32'h100);
    chk("stop_gpio", 32'(gpio), 32'h11);
    wr(A_DIR, 32'h55);
    chk("dir_idle", 32'(gpio), 32'h55);
    rdr(A_DIR, rd);
    chk("dir_read", rd, 32'h55);

    // reset in the middle of a hold
    for (int i = 1; i <= 4; i++)
      wr(A_PUSH, 32'h0032_0000 | 32'(i));
    wr(A_CTRL, 32'h1);
    rdr(A_STAT, rd);
    chk("mid_status", rd & 32'h70F, 32'h403);
    repeat (5) step();
    wb_rst = 1'b1;
    step();
    chk("mid_rst_gpio", 32'(gpio), 32'h0);
    chk("mid_rst_ack", 32'(bus.ack), 32'h0);
    wb_rst = 1'b0;
    rdr(A_STAT, rd);
    chk("mid_rst_stat", rd, 32'h100);
    rdr(A_CTRL, rd);
    chk("mid_rst_ctrl", rd, 32'h0);

    // non-matching address never acks
    begin
      int acks;
      acks = 0;
      bus.wb_dbus_adr = 32'h0100_0008;
      bus.wb_dbus_we  = 1'b0;
      bus.wb_dbus_cyc = 1'b1;
      for (int i = 0; i < 8; i++) begin
        step();
        if (bus.ack) acks++;
      end
      bus.wb_dbus_cyc = 1'b0;
      chk("nomatch_ack", 32'(acks), 32'h0);
    end
    step();

`ifdef GPIO_SEQ_IRQ_EN
    begin
      int k;
      for (int i = 1; i <= 4; i++)
        wr(A_PUSH, 32'h0001_0000 | 32'(i));
      wr(A_CTRL, 32'h1);
      chk("irq_low_start", 32'(irq), 32'h0);
      k = 0;
      while (!irq && k < 20) begin
        step();
        k++;
      end
      chk("irq_rise", 32'(irq), 32'h1);
      rdr(A_STAT, rd);
      chk("irq_count", rd & 32'hF, 32'h2);
      wait_idle();
      rdr(A_STAT, rd);
      chk("irq_underrun", rd & 32'h1_0800, 32'h1_0800);
      chk("irq_held", 32'(irq), 32'h1);
      wr(A_CTRL, 32'h0);
      wr(A_STAT, 32'h0001_0000);
      step();
      chk("irq_clear", 32'(irq), 32'h0);
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

endmodule
